// File: rtl/trees_pkg.sv
// Shared types and sizing for the feature burst loader: bank status, FSM states,
// words-per-sample and address/length widths.
package trees_pkg;

  localparam int N_FEATURE = 32;
  localparam int MAX_BURST = 5000;
  localparam int WPS       = N_FEATURE / 2;
  localparam int LEN_W     = $clog2(MAX_BURST) + 1;
  localparam int ADDR_W    = $clog2(MAX_BURST * N_FEATURE / 2);

  typedef enum logic [1:0] {FREE, FULL, BUSY} bank_status_t;
  typedef enum logic {F_IDLE, F_LOAD} fill_state_t;
  typedef enum logic [1:0] {D_IDLE, D_START, D_RUN} disp_state_t;

  function automatic logic len_ok(input logic [LEN_W-1:0] n);
    return (n != '0) && (n <= LEN_W'(MAX_BURST));
  endfunction

endpackage

// File: rtl/feature_burst_loader_if.sv
// Bundle of descriptor, feature stream, engine and result signals of the loader.
// slave = loader side, master = upstream feeder / engine side.
interface feature_burst_loader_if;
  import trees_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [LEN_W-1:0]  cfg_burst_len;
  logic              s_valid;
  logic              s_ready;
  logic [63:0]       s_data;
  logic              load_features;
  logic [ADDR_W-1:0] feature_addr;
  logic [63:0]       features2;
  logic              m_ping_pong;
  logic              e_ping_pong;
  logic [LEN_W-1:0]  burst_len;
  logic              start;
  logic              idle;
  logic              done;
  logic              res_ready;
  logic              res_valid;
  logic [LEN_W-1:0]  res_len;
  logic              cfg_err;
  logic [31:0]       stat_bursts;
  logic [31:0]       stat_stall;

  modport slave (
    input  cfg_valid, cfg_burst_len, s_valid, s_data, idle, done, res_ready,
    output cfg_ready, s_ready, load_features, feature_addr, features2,
           m_ping_pong, e_ping_pong, burst_len, start, res_valid, res_len,
           cfg_err, stat_bursts, stat_stall
  );

  modport master (
    output cfg_valid, cfg_burst_len, s_valid, s_data, idle, done, res_ready,
    input  cfg_ready, s_ready, load_features, feature_addr, features2,
           m_ping_pong, e_ping_pong, burst_len, start, res_valid, res_len,
           cfg_err, stat_bursts, stat_stall
  );

endinterface

// File: rtl/feature_burst_loader_bank_tracker.sv
// Two-entry ping/pong bank status and stored burst length, updated by the
// fill side (set-full) and dispatch side (set-busy, release).
module bank_tracker
  import trees_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_full,
  input  logic             full_bank,
  input  logic [LEN_W-1:0] full_len,
  input  logic             set_busy,
  input  logic             busy_bank,
  input  logic             rel,
  input  logic             rel_bank,
  output bank_status_t     status [2],
  output logic [LEN_W-1:0] len [2]
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      localparam logic ID = 1'(gi);
      bank_status_t     st_reg;
      logic [LEN_W-1:0] len_reg;

      // Fill and dispatch never target the same bank in one cycle, so the
      // priority order here only matters for illegal stimulus.
      always_ff @(posedge clk) begin
        if (rst) begin
          st_reg  <= FREE;
          len_reg <= '0;
        end else if (set_full && full_bank == ID) begin
          st_reg  <= FULL;
          len_reg <= full_len;
        end else if (set_busy && busy_bank == ID) begin
          st_reg  <= BUSY;
        end else if (rel && rel_bank == ID) begin
          st_reg  <= FREE;
        end
      end

      assign status[gi] = st_reg;
      assign len[gi]    = len_reg;
    end
  endgenerate

endmodule

// File: rtl/feature_burst_loader.sv
// Ping/pong feature bank loader and engine dispatcher.
// Optional statistics counters: define FEATURE_LOADER_STATS_EN.
module feature_burst_loader
  import trees_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  feature_burst_loader_if.slave bus
);

  bank_status_t     status [2];
  logic [LEN_W-1:0] len [2];

  fill_state_t       fill_state_reg, fill_state_next;
  logic              fill_bank_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [ADDR_W-1:0] wlast_reg;
  logic [LEN_W-1:0]  fill_len_reg;
  logic              m_pp_reg;
  logic              cfg_err_reg;
  logic              cfg_ready;
  logic              s_ready;
  logic              set_full;
  logic              cfg_fire;
  logic              cfg_good;
  logic              word_fire;

  disp_state_t       disp_state_reg, disp_state_next;
  logic              exec_bank_reg;
  logic              e_pp_reg;
  logic [LEN_W-1:0]  burst_len_reg;
  logic              res_valid_reg;
  logic [LEN_W-1:0]  res_len_reg;
  logic              start;
  logic              set_busy;
  logic              rel;
  logic              dispatch_go;

  assign cfg_fire  = bus.cfg_valid & cfg_ready;
  assign cfg_good  = len_ok(bus.cfg_burst_len);
  assign word_fire = bus.s_valid & s_ready;

  always_comb begin
    fill_state_next = fill_state_reg;
    cfg_ready       = 1'b0;
    s_ready         = 1'b0;
    set_full        = 1'b0;
    case (fill_state_reg)
      F_IDLE: begin
        cfg_ready = (status[fill_bank_reg] == FREE);
        if (bus.cfg_valid && cfg_ready && cfg_good) fill_state_next = F_LOAD;
      end
      F_LOAD: begin
        s_ready = 1'b1;
        if (bus.s_valid && wr_addr_reg == wlast_reg) begin
          set_full        = 1'b1;
          fill_state_next = F_IDLE;
        end
      end
      default: fill_state_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) fill_state_reg <= F_IDLE;
    else     fill_state_reg <= fill_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_bank_reg <= 1'b0;
      wr_addr_reg   <= '0;
      wlast_reg     <= '0;
      fill_len_reg  <= '0;
      m_pp_reg      <= 1'b1;
      cfg_err_reg   <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_fire & ~cfg_good;
      if (cfg_fire && cfg_good) begin
        // In-range lengths never exceed the address width, so no wrap here.
        wlast_reg    <= ADDR_W'(bus.cfg_burst_len) * ADDR_W'(WPS) - ADDR_W'(1);
        wr_addr_reg  <= '0;
        fill_len_reg <= bus.cfg_burst_len;
        m_pp_reg     <= (fill_bank_reg == 1'b0);
      end
      if (word_fire) wr_addr_reg <= wr_addr_reg + ADDR_W'(1);
      if (set_full)  fill_bank_reg <= ~fill_bank_reg;
    end
  end

  always_comb begin
    disp_state_next = disp_state_reg;
    start           = 1'b0;
    set_busy        = 1'b0;
    rel             = 1'b0;
    dispatch_go     = 1'b0;
    case (disp_state_reg)
      D_IDLE: begin
        if (status[exec_bank_reg] == FULL && bus.idle && bus.res_ready) begin
          dispatch_go     = 1'b1;
          disp_state_next = D_START;
        end
      end
      D_START: begin
        start           = 1'b1;
        set_busy        = 1'b1;
        disp_state_next = D_RUN;
      end
      D_RUN: begin
        if (bus.done) begin
          rel             = 1'b1;
          disp_state_next = D_IDLE;
        end
      end
      default: disp_state_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) disp_state_reg <= D_IDLE;
    else     disp_state_reg <= disp_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exec_bank_reg <= 1'b0;
      e_pp_reg      <= 1'b1;
      burst_len_reg <= '0;
      res_valid_reg <= 1'b0;
      res_len_reg   <= '0;
    end else begin
      res_valid_reg <= rel;
      if (dispatch_go) begin
        e_pp_reg      <= (exec_bank_reg == 1'b0);
        burst_len_reg <= len[exec_bank_reg];
      end
      if (rel) begin
        res_len_reg   <= len[exec_bank_reg];
        exec_bank_reg <= ~exec_bank_reg;
      end
    end
  end

  bank_tracker u_bank_tracker (
    .clk       (clk),
    .rst       (rst),
    .set_full  (set_full),
    .full_bank (fill_bank_reg),
    .full_len  (fill_len_reg),
    .set_busy  (set_busy),
    .busy_bank (exec_bank_reg),
    .rel       (rel),
    .rel_bank  (exec_bank_reg),
    .status    (status),
    .len       (len)
  );

`ifdef FEATURE_LOADER_STATS_EN
  logic [31:0] stat_bursts_reg;
  logic [31:0] stat_stall_reg;
  logic        stall_cycle;

  assign stall_cycle = (disp_state_reg == D_IDLE) && (status[exec_bank_reg] == FULL) &&
                       !(bus.idle && bus.res_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bursts_reg <= '0;
      stat_stall_reg  <= '0;
    end else begin
      if (res_valid_reg && stat_bursts_reg != '1) stat_bursts_reg <= stat_bursts_reg + 32'd1;
      if (stall_cycle && stat_stall_reg != '1)    stat_stall_reg  <= stat_stall_reg + 32'd1;
    end
  end

  assign bus.stat_bursts = stat_bursts_reg;
  assign bus.stat_stall  = stat_stall_reg;
`else
  assign bus.stat_bursts = '0;
  assign bus.stat_stall  = '0;
`endif

  assign bus.cfg_ready     = cfg_ready;
  assign bus.s_ready       = s_ready;
  assign bus.load_features = word_fire;
  assign bus.feature_addr  = wr_addr_reg;
  assign bus.features2     = bus.s_data;
  assign bus.m_ping_pong   = m_pp_reg;
  assign bus.e_ping_pong   = e_pp_reg;
  assign bus.burst_len     = burst_len_reg;
  assign bus.start         = start;
  assign bus.res_valid     = res_valid_reg;
  assign bus.res_len       = res_len_reg;
  assign bus.cfg_err       = cfg_err_reg;

endmodule
